// File: rtl/hue_wheel_sequencer_pkg.sv
// Shared types for the RGB hue wheel sequencer: FSM states and the six
// 60-degree stage codes (red->yellow ... magenta->red).
package hue_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [2:0] stage_t;

  localparam stage_t STG_RY = 3'd0;
  localparam stage_t STG_YG = 3'd1;
  localparam stage_t STG_GC = 3'd2;
  localparam stage_t STG_CB = 3'd3;
  localparam stage_t STG_BM = 3'd4;
  localparam stage_t STG_MR = 3'd5;

  localparam int NUM_STAGES = 6;

  function automatic stage_t next_stage(input stage_t s);
    return (s == stage_t'(NUM_STAGES - 1)) ? STG_RY : stage_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/hue_wheel_sequencer_step_prescaler.sv
// Step-rate prescaler: emits a registered one-cycle step_tick every
// STEP_CYCLES clocks of run_en; frozen while run_en is low, zeroed by clr.
module step_prescaler
  import hue_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clr,
  output logic step_tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (run_en) begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign step_tick = r_tick;

endmodule

// File: rtl/hue_wheel_sequencer.sv
// Six-stage RGB hue wheel sequencer with run/pause/single-step control.
// Optional HUE_PWM_OUT_EN adds built-in PWM comparators (pwm_r/g/b).
module hue_wheel_sequencer
  import hue_seq_pkg::*;
#(
  parameter int  STEP_CYCLES     = 10000,
  parameter int  STEPS_PER_STAGE = 200,
  parameter int  PWM_INTERVAL    = 1200,
  localparam int STEP_VAL        = PWM_INTERVAL / STEPS_PER_STAGE,
  localparam int DUTY_W          = $clog2(PWM_INTERVAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              hold,
  input  logic              step_i,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        stage,
  output logic              stage_done,
  output logic              cycle_done,
  output logic              running
`ifdef HUE_PWM_OUT_EN
  ,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b
`endif
);

  localparam int SC_W = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;
  localparam logic [SC_W-1:0]   LAST_STEP = SC_W'(STEPS_PER_STAGE - 1);
  localparam logic [DUTY_W-1:0] FULL      = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] INC       = DUTY_W'(STEP_VAL);

  state_t            r_state;
  stage_t            r_stage;
  logic [SC_W-1:0]   r_step_cnt;
  logic [DUTY_W-1:0] r_duty_r, r_duty_g, r_duty_b;
  logic              r_stage_done, r_cycle_done, r_running;

  logic w_tick, w_step, w_last, w_run_en, w_clr;

  assign w_run_en = (r_state == RUN);
  assign w_clr    = !enable || (r_state == IDLE);
  assign w_step   = w_tick || ((r_state == PAUSE) && step_i);
  assign w_last   = (r_step_cnt == LAST_STEP);

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run_en   (w_run_en),
    .clr      (w_clr),
    .step_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    // NOTE: rst and a dropped enable share one branch, so leaving IDLE always starts from pure red.
    if (rst || !enable) begin
      r_state      <= IDLE;
      r_stage      <= STG_RY;
      r_step_cnt   <= '0;
      r_duty_r     <= FULL;
      r_duty_g     <= '0;
      r_duty_b     <= '0;
      r_stage_done <= 1'b0;
      r_cycle_done <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_state <= hold ? PAUSE : RUN;
        RUN:     if (hold)  r_state <= PAUSE;
        PAUSE:   if (!hold) r_state <= RUN;
        default: r_state <= IDLE;
      endcase
      r_running    <= !hold;
      r_stage_done <= 1'b0;
      r_cycle_done <= 1'b0;

      if (w_step) begin
        if (w_last) begin
          r_step_cnt   <= '0;
          r_stage      <= next_stage(r_stage);
          r_stage_done <= 1'b1;
          r_cycle_done <= (r_stage == STG_MR);
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end

        // The final step of a stage snaps to the rail so rounding can never wrap.
        case (r_stage)
          STG_RY:  r_duty_g <= w_last ? FULL : r_duty_g + INC;
          STG_YG:  r_duty_r <= w_last ? '0   : r_duty_r - INC;
          STG_GC:  r_duty_b <= w_last ? FULL : r_duty_b + INC;
          STG_CB:  r_duty_g <= w_last ? '0   : r_duty_g - INC;
          STG_BM:  r_duty_r <= w_last ? FULL : r_duty_r + INC;
          STG_MR:  r_duty_b <= w_last ? '0   : r_duty_b - INC;
          default: ;
        endcase
      end
    end
  end

  assign duty_r     = r_duty_r;
  assign duty_g     = r_duty_g;
  assign duty_b     = r_duty_b;
  assign stage      = r_stage;
  assign stage_done = r_stage_done;
  assign cycle_done = r_cycle_done;
  assign running    = r_running;

`ifdef HUE_PWM_OUT_EN
  logic [DUTY_W-1:0] r_period;
  logic              r_pwm_r, r_pwm_g, r_pwm_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
      r_pwm_r  <= 1'b0;
      r_pwm_g  <= 1'b0;
      r_pwm_b  <= 1'b0;
    end else begin
      r_period <= (r_period == FULL - 1'b1) ? '0 : r_period + 1'b1;
      r_pwm_r  <= (r_period < r_duty_r);
      r_pwm_g  <= (r_period < r_duty_g);
      r_pwm_b  <= (r_period < r_duty_b);
    end
  end

  assign pwm_r = r_pwm_r;
  assign pwm_g = r_pwm_g;
  assign pwm_b = r_pwm_b;
`endif

endmodule

// File: tb/tb_hue_wheel_sequencer.sv
// Self-checking bench for hue_wheel_sequencer with a hue-position reference model.
module tb_hue_wheel_sequencer;

  localparam int SC   = 4;
  localparam int N    = 4;
  localparam int FULL = 12;
  localparam int SV   = FULL / N;
  localparam int DW   = 4;

  logic          clk = 1'b0;
  logic          rst, enable, hold, step_i;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [2:0]    stage;
  logic          stage_done, cycle_done, running;
`ifdef HUE_PWM_OUT_EN
  logic          pwm_r, pwm_g, pwm_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle / 1 run / 2 pause, prescaler count,
  // pending step pulse and hue position 0 .. 6*N-1 around the wheel.
  int m_mode, m_pre, m_pos;
  bit m_tick, m_sd, m_cd, m_run;

  logic [DW*3+5:0] act;
  assign act = {duty_r, duty_g, duty_b, stage, stage_done, cycle_done, running};

  hue_wheel_sequencer #(
    .STEP_CYCLES    (SC),
    .STEPS_PER_STAGE(N),
    .PWM_INTERVAL   (FULL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .hold      (hold),
    .step_i    (step_i),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .stage     (stage),
    .stage_done(stage_done),
    .cycle_done(cycle_done),
    .running   (running)
`ifdef HUE_PWM_OUT_EN
    ,
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW*3+5:0] model_vec();
    int s, up, r, g, b;
    s  = m_pos / N;
    up = (m_pos % N) * SV;
    case (s)
      0:       begin r = FULL;      g = up;        b = 0;         end
      1:       begin r = FULL - up; g = FULL;      b = 0;         end
      2:       begin r = 0;         g = FULL;      b = up;        end
      3:       begin r = 0;         g = FULL - up; b = FULL;      end
      4:       begin r = up;        g = 0;         b = FULL;      end
      default: begin r = FULL;      g = 0;         b = FULL - up; end
    endcase
    return {DW'(r), DW'(g), DW'(b), 3'(s), m_sd, m_cd, m_run};
  endfunction

  task automatic model_edge();
    bit adv;
    m_sd = 1'b0;
    m_cd = 1'b0;
    if (rst || !enable) begin
      m_mode = 0; m_pre = 0; m_tick = 1'b0; m_pos = 0; m_run = 1'b0;
    end else begin
      adv = m_tick || (m_mode == 2 && step_i);
      if (m_mode == 1) begin
        m_tick = (m_pre == SC - 1);
        m_pre  = (m_pre + 1) % SC;
      end else begin
        m_tick = 1'b0;
      end
      if (adv) begin
        m_pos = (m_pos + 1) % (6 * N);
        m_sd  = (m_pos % N == 0);
        m_cd  = (m_pos == 0);
      end
      m_mode = hold ? 2 : 1;
      m_run  = !hold;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; hold = 1'b0; step_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    n_checks++;
    if (act !== model_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", act, model_vec());
    end
    n_checks++;
    if (act !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: got %h expected c00000", act);
    end
  endtask

  task automatic test_first_steps();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL first_steps cyc %0d: got %h expected %h", k, act, model_vec());
      end
      if (k == 4 || k == 5 || k == 9 || k == 13) begin
        n_checks++;
        if (duty_g !== DW'(k == 4 ? 0 : 3 * ((k - 1) / 4))) begin
          n_fail++; $display("FAIL first_g cyc %0d: got %0d", k, duty_g);
        end
      end
      if (k == 17) begin
        n_checks++;
        if ({duty_g, stage, stage_done} !== {4'd12, 3'd1, 1'b1}) begin
          n_fail++; $display("FAIL first_stage_end: got g=%0d stage=%0d sd=%b expected 12/1/1",
                             duty_g, stage, stage_done);
        end
      end
    end
  endtask

  task automatic test_full_run();
    logic [11:0] ends [6];
    logic [11:0] want [6];
    int n_sd, n_cd;
    want = '{{4'd12, 4'd12, 4'd0}, {4'd0, 4'd12, 4'd0}, {4'd0, 4'd12, 4'd12},
             {4'd0, 4'd0, 4'd12}, {4'd12, 4'd0, 4'd12}, {4'd12, 4'd0, 4'd0}};
    n_sd = 0; n_cd = 0;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k <= 105; k++) begin
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL full_run cyc %0d: got %h expected %h", k, act, model_vec());
      end
      if (stage_done === 1'b1) begin
        if (n_sd < 6) ends[n_sd] = {duty_r, duty_g, duty_b};
        n_sd++;
      end
      if (cycle_done === 1'b1) begin
        n_cd++;
        n_checks++;
        if (stage !== 3'd0) begin
          n_fail++; $display("FAIL cycle_done_stage: got %0d expected 0", stage);
        end
      end
    end
    n_checks++;
    if (n_sd != 6 || n_cd != 1) begin
      n_fail++; $display("FAIL full_run_pulses: got sd=%0d cd=%0d expected 6/1", n_sd, n_cd);
    end
    for (int i = 0; i < 6 && i < n_sd; i++) begin
      n_checks++;
      if (ends[i] !== want[i]) begin
        n_fail++; $display("FAIL stage_end %0d: got %h expected %h", i, ends[i], want[i]);
      end
    end
  endtask

  task automatic test_hold();
    int off;
    off = $urandom_range(0, 3);
    do_reset();
    enable = 1'b1;
    for (int k = 0; k <= 9 + off; k++) cyc();
    hold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL hold cyc %0d off %0d: got %h expected %h", k, off, act, model_vec());
      end
    end
    n_checks++;
    if ({duty_r, duty_g, duty_b, running} !== {4'd12, DW'(off >= 2 ? 9 : 6), 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL hold_frozen off %0d: got %0d/%0d/%0d run=%b", off,
                         duty_r, duty_g, duty_b, running);
    end
    hold = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL resume cyc %0d: got %h expected %h", k, act, model_vec());
      end
    end
  endtask

  task automatic test_manual_step();
    do_reset();
    enable = 1'b1; hold = 1'b1;
    cyc();
    for (int p = 1; p <= 4; p++) begin
      step_i = 1'b1;
      cyc();
      step_i = 1'b0;
      n_checks++;
      if ({duty_g, stage, stage_done} !== {DW'(3 * p), 3'(p == 4), 1'(p == 4)}) begin
        n_fail++; $display("FAIL manual_step %0d: got g=%0d stage=%0d sd=%b", p, duty_g, stage, stage_done);
      end
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL manual_gap %0d: got %h expected %h", p, act, model_vec());
      end
    end
    hold = 1'b0;
    cyc();
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    n_checks++;
    if ({duty_r, duty_g, stage, running} !== {4'd12, 4'd12, 3'd1, 1'b1} || act !== model_vec()) begin
      n_fail++; $display("FAIL step_in_run: got %h expected %h", act, model_vec());
    end
  endtask

  task automatic test_enable_and_rst_drop();
    int guard;
    do_reset();
    enable = 1'b1;
    guard = 0;
    while (stage !== 3'd3 && guard < 200) begin cyc(); guard++; end
    n_checks++;
    if (guard >= 200) begin n_fail++; $display("FAIL reach_stage3: timeout, stage=%0d", stage); end
    repeat ($urandom_range(0, 5)) cyc();
    enable = 1'b0;
    cyc();
    n_checks++;
    if (act !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL enable_drop: got %h expected c00000", act);
    end
    enable = 1'b1;
    guard = 0;
    while (stage !== 3'd4 && guard < 200) begin cyc(); guard++; end
    n_checks++;
    if (guard >= 200) begin n_fail++; $display("FAIL reach_stage4: timeout, stage=%0d", stage); end
    repeat ($urandom_range(1, 6)) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if (act !== {4'd12, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0} || act !== model_vec()) begin
      n_fail++; $display("FAIL rst_mid_stage: got %h expected c00000", act);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 24) != 0);
      hold   = ($urandom_range(0, 3) == 0);
      step_i = ($urandom_range(0, 2) == 0);
      cyc();
      n_checks++;
      if (act !== model_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", k, act, model_vec());
      end
    end
    rst = 1'b0; enable = 1'b1; hold = 1'b0; step_i = 1'b0;
  endtask

`ifdef HUE_PWM_OUT_EN
  task automatic test_pwm();
    int ones_r, ones_g, ones_b;
    do_reset();
    enable = 1'b1; hold = 1'b1;
    cyc();
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    cyc();
    ones_r = 0; ones_g = 0; ones_b = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      ones_r += int'(pwm_r);
      ones_g += int'(pwm_g);
      ones_b += int'(pwm_b);
    end
    n_checks++;
    if (ones_r != 12 || ones_g != 3 || ones_b != 0) begin
      n_fail++; $display("FAIL pwm_counts: got r=%0d g=%0d b=%0d expected 12/3/0", ones_r, ones_g, ones_b);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; hold = 1'b0; step_i = 1'b0;
    m_mode = 0; m_pre = 0; m_pos = 0;
    m_tick = 1'b0; m_sd = 1'b0; m_cd = 1'b0; m_run = 1'b0;
    test_reset();
    test_first_steps();
    test_full_run();
    test_hold();
    test_manual_step();
    test_enable_and_rst_drop();
    test_random();
`ifdef HUE_PWM_OUT_EN
    test_pwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
